// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one AND/ADD/SUB alu between two requesters
// Optional build macro ALU_STATS_EN adds saturating stat_ops/stat_ovf response counters.

module alu (
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] result,
    output logic        overflow,
    output logic        equal,
    output logic        zero
);
    logic [32:0] sum;
    logic [31:0] neg_y;

    // overflow is the raw adder carry-out; SUB adds the two's complement of y
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        sum      = '0;
        neg_y    = ~y + 32'd1;
        case (op)
            2'b00: result = x & y;
            2'b01: begin
                sum      = {1'b0, x} + {1'b0, y};
                result   = sum[31:0];
                overflow = sum[32];
            end
            2'b10: begin
                sum      = {1'b0, x} + {1'b0, neg_y};
                result   = sum[31:0];
                overflow = sum[32];
            end
            default: ;
        endcase
    end

    assign equal = ~|(x ^ y);
    assign zero  = ~|result;
endmodule

module alu_arbiter
`ifdef ALU_STATS_EN
    #(parameter int CNT_W = 16)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_overflow,
    output logic        resp_equal,
    output logic        resp_zero
`ifdef ALU_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_ovf
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nx;
    logic        last_grant;
    logic        grant0, grant1;
    logic [1:0]  op_q;
    logic [31:0] x_q, y_q;
    logic        id_q;
    logic [31:0] alu_result;
    logic        alu_overflow, alu_equal, alu_zero;

    // on a tie the requester that did not win last time is granted
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    alu u_alu (
        .op       (op_q),
        .x        (x_q),
        .y        (y_q),
        .result   (alu_result),
        .overflow (alu_overflow),
        .equal    (alu_equal),
        .zero     (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 & rst_n;
                req1_ready = grant1 & rst_n;
                if (grant0 | grant1) state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= 1'b1;
            op_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            id_q          <= 1'b0;
            resp_id       <= 1'b0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_equal    <= 1'b0;
            resp_zero     <= 1'b0;
        end else begin
            if (state == IDLE && (grant0 | grant1)) begin
                op_q       <= grant1 ? req1_op : req0_op;
                x_q        <= grant1 ? req1_x  : req0_x;
                y_q        <= grant1 ? req1_y  : req0_y;
                id_q       <= grant1;
                last_grant <= grant1;
            end
            if (state == EXEC) begin
                resp_id       <= id_q;
                resp_result   <= alu_result;
                resp_overflow <= alu_overflow;
                resp_equal    <= alu_equal;
                resp_zero     <= alu_zero;
            end
        end
    end

`ifdef ALU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (resp_valid && resp_ready) begin
            if (stat_ops != '1) stat_ops <= stat_ops + 1'b1;
            if (resp_overflow && stat_ovf != '1) stat_ovf <= stat_ovf + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - table-driven scoreboard bench for alu_arbiter

module tb_alu_arbiter;
    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        ovf;
        logic        eq;
        logic        zr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic        resp_valid, resp_ready = 1'b1;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_overflow, resp_equal, resp_zero;
`ifdef ALU_STATS_EN
    logic [15:0] stat_ops, stat_ovf;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int exp_ops = 0;
    int exp_ovf = 0;
    vec_t q[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

`ifdef ALU_STATS_EN
    alu_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_overflow(resp_overflow),
        .resp_equal(resp_equal), .resp_zero(resp_zero),
        .stat_ops(stat_ops), .stat_ovf(stat_ovf)
    );
`else
    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_overflow(resp_overflow),
        .resp_equal(resp_equal), .resp_zero(resp_zero)
    );
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic id, input logic [1:0] op, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] res,
                                input logic ovf, input logic eq, input logic zr);
        vec_t v;
        v.id = id; v.op = op; v.x = x; v.y = y;
        v.res = res; v.ovf = ovf; v.eq = eq; v.zr = zr;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = q.pop_front();
                chk("resp_id", {31'd0, resp_id}, {31'd0, e.id});
                chk("resp_result", resp_result, e.res);
                chk("resp_overflow", {31'd0, resp_overflow}, {31'd0, e.ovf});
                chk("resp_equal", {31'd0, resp_equal}, {31'd0, e.eq});
                chk("resp_zero", {31'd0, resp_zero}, {31'd0, e.zr});
                exp_ops++;
                if (e.ovf) exp_ovf++;
            end
        end
    end

    task automatic drive(input logic id, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y; end
    endtask

    task automatic issue(input vec_t v);
        bit got = 0;
        @(posedge clk); #1;
        drive(v.id, v.op, v.x, v.y);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((v.id ? req1_ready : req0_ready) === 1'b1) begin got = 1; break; end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        else q.push_back(v);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (q.size() != 0 && i < 30) begin @(negedge clk); i++; end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_id"}, {31'd0, resp_id}, 32'd0);
        chk({tag, "_resp_result"}, resp_result, 32'd0);
        chk({tag, "_flags"}, {29'd0, resp_overflow, resp_equal, resp_zero}, 32'd0);
        chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        exp_ops = 0; exp_ovf = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_res;
        logic [3:0]  snap_flags;
        int          ng;

        tbl[0] = mk(1'b0, 2'b01, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 2'b00, 32'hFFFF0000,  32'h0F0F0F0F,  32'h0F0F0000,  1'b0, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 2'b01, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0, 1'b1);
        tbl[3] = mk(1'b1, 2'b10, 32'd9,         32'd9,         32'd0,         1'b1, 1'b1, 1'b1);
        tbl[4] = mk(1'b0, 2'b11, 32'd3,         32'd3,         32'd0,         1'b0, 1'b1, 1'b1);
        tbl[5] = mk(1'b1, 2'b10, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0, 1'b0, 1'b0);
        tbl[6] = mk(1'b0, 2'b10, 32'd7,         32'd5,         32'd2,         1'b1, 1'b0, 1'b0);
        tbl[7] = mk(1'b1, 2'b11, 32'd1,         32'd2,         32'd0,         1'b0, 1'b0, 1'b1);
        tbl[8] = mk(1'b0, 2'b00, 32'd0,         32'hFFFFFFFF,  32'd0,         1'b0, 1'b0, 1'b1);
        tbl[9] = mk(1'b1, 2'b01, 32'h80000000,  32'h80000000,  32'd0,         1'b1, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst_n = 1'b1;

        // first-op latency: accept at edge N, resp_valid after N+1
        @(posedge clk); #1;
        drive(1'b0, 2'b01, 32'd5, 32'd7);
        @(negedge clk);
        chk("lat_req0_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        q.push_back(tbl[0]);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("lat_exec_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_resp_valid", {31'd0, resp_valid}, 32'd1);
        drain();

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i]);
            drain();
        end

        // stalled consumer: response must hold and nothing new is accepted
        resp_ready = 1'b0;
        issue(tbl[3]);
        drive(1'b0, 2'b01, 32'd1, 32'd1);
        drive(1'b1, 2'b01, 32'd2, 32'd2);
        @(negedge clk); @(negedge clk);
        snap_res = resp_result;
        snap_flags = {resp_id, resp_overflow, resp_equal, resp_zero};
        chk("stall_result", snap_res, 32'd0);
        chk("stall_flags", {28'd0, snap_flags}, 32'hF);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_hold", {resp_result[27:0], resp_id, resp_overflow, resp_equal, resp_zero},
                {snap_res[27:0], snap_flags});
            chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        drain();

        // fairness from reset: continuous ties alternate 0,1,0,1
        do_reset();
        drive(1'b0, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F);
        drive(1'b1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F);
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                logic eid;
                eid = ng[0];
                chk("rr_grant", {30'd0, req1_ready, req0_ready}, eid ? 32'd2 : 32'd1);
                q.push_back(mk(eid, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0, 1'b0));
                ng++;
            end
        end
        chk("rr_grants", ng, 32'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // reset during EXEC drops the op; next tie goes to req0
        issue(mk(1'b1, 2'b01, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 2'b01, 32'd2, 32'd3);
        drive(1'b1, 2'b01, 32'd4, 32'd4);
        rst_n = 1'b0;
        q.delete();
        exp_ops = 0; exp_ovf = 0;
        #1 check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
        q.push_back(mk(1'b0, 2'b01, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        issue(tbl[2]);
        drain();
`ifdef ALU_STATS_EN
        chk("stat_ops", {16'd0, stat_ops}, exp_ops);
        chk("stat_ovf", {16'd0, stat_ovf}, exp_ovf);
`endif
        chk("final_ops_seen", exp_ops, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
